// File: rtl/decision_framer.sv
// decision_framer: serializes one decision plus its latencies into a
// 15-byte UART frame and keeps frame count / worst-case latency stats.
module decision_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  dec_type,
  input  logic [31:0] dec_data,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [31:0] t_ingress,
  input  logic [31:0] t_parser,
  input  logic [31:0] t_decision,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        clear_stats,
  output logic [15:0] frame_count,
  output logic [31:0] max_lat
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  idx;
  logic [3:0]  idx_inc;
  logic [7:0]  type_q;
  logic [31:0] data_q;
  logic [31:0] plat_q;
  logic [31:0] tlat_q;
  logic [31:0] plat_in;
  logic [31:0] tlat_in;
  logic [7:0]  csum;
  logic [7:0]  sel;
  logic        accept;
  logic        hs;
  logic        last;
  logic [15:0] fc_base;
  logic [15:0] fc_next;
  logic [31:0] max_base;
  logic [31:0] max_next;

  assign dec_ready = (state == IDLE);
  assign tx_valid  = (state == SEND);
  assign accept    = dec_valid && dec_ready;
  assign hs        = tx_valid && tx_ready;
  assign last      = hs && (idx == 4'd14);
  assign idx_inc   = idx + 4'd1;

  // Modulo-2^32 differences: timestamp wrap still yields the true delta.
  assign plat_in = t_parser - t_ingress;
  assign tlat_in = t_decision - t_ingress;

  assign csum = type_q
    ^ data_q[31:24] ^ data_q[23:16]
    ^ data_q[15:8]  ^ data_q[7:0]
    ^ plat_q[31:24] ^ plat_q[23:16]
    ^ plat_q[15:8]  ^ plat_q[7:0]
    ^ tlat_q[31:24] ^ tlat_q[23:16]
    ^ tlat_q[15:8]  ^ tlat_q[7:0];

  // Byte for the index that follows the current handshake.
  always_comb begin
    sel = 8'h00;
    case (idx_inc)
      4'd1:    sel = type_q;
      4'd2:    sel = data_q[31:24];
      4'd3:    sel = data_q[23:16];
      4'd4:    sel = data_q[15:8];
      4'd5:    sel = data_q[7:0];
      4'd6:    sel = plat_q[31:24];
      4'd7:    sel = plat_q[23:16];
      4'd8:    sel = plat_q[15:8];
      4'd9:    sel = plat_q[7:0];
      4'd10:   sel = tlat_q[31:24];
      4'd11:   sel = tlat_q[23:16];
      4'd12:   sel = tlat_q[15:8];
      4'd13:   sel = tlat_q[7:0];
      4'd14:   sel = csum;
      default: sel = 8'h00;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture registers, byte index and the registered output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q  <= 8'h00;
      data_q  <= 32'h0;
      plat_q  <= 32'h0;
      tlat_q  <= 32'h0;
      idx     <= 4'd0;
      tx_byte <= 8'h00;
    end else if (accept) begin
      type_q  <= dec_type;
      data_q  <= dec_data;
      plat_q  <= plat_in;
      tlat_q  <= tlat_in;
      idx     <= 4'd0;
      tx_byte <= SYNC_BYTE;
    end else if (hs) begin
      idx     <= last ? 4'd0 : idx_inc;
      tx_byte <= sel;
    end
  end

  // Clear wins first, then the coincident event is applied on top.
  always_comb begin
    fc_base  = clear_stats ? 16'h0 : frame_count;
    fc_next  = last ? fc_base + 16'd1 : fc_base;
    max_base = clear_stats ? 32'h0 : max_lat;
    max_next = max_base;
    if (accept && (tlat_in > max_base)) max_next = tlat_in;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= 16'h0;
      max_lat     <= 32'h0;
    end else begin
      frame_count <= fc_next;
      max_lat     <= max_next;
    end
  end

endmodule
